// File: rtl/phi_copy_sequencer.sv
// Sequentializes one parallel-copy set into an ordered stream of single moves.
// Cycles such as swaps are broken through the reserved temporary register TMP_REG.
module phi_copy_sequencer #(
  parameter int REG_W   = 8,
  parameter int DEPTH   = 8,
  parameter int TMP_REG = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_dest,
  input  logic [REG_W-1:0] in_src,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_dest,
  output logic [REG_W-1:0] out_src,
  output logic             out_last,
  output logic             set_done,
  output logic             err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [REG_W-1:0] TMP = REG_W'(TMP_REG);

  typedef enum logic [1:0] {COLLECT, SCHED, EMIT} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   tbl_vld;
  logic [REG_W-1:0]   tbl_dest [DEPTH];
  logic [REG_W-1:0]   tbl_src  [DEPTH];
  logic [REG_W-1:0]   out_dest_q, out_src_q;
  logic               out_last_q, set_done_q, err_q;

  logic               have_free, dup_hit;
  logic [IDX_W-1:0]   free_idx;
  logic [DEPTH-1:0]   rdy;
  logic               rdy_any, rdy_last;
  logic [IDX_W-1:0]   rdy_idx, vld_idx;
  logic               in_take, in_store, in_bad;
  logic               load_rdy, load_tmp, done_d;

  // Insertion slot and duplicate-destination detection
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    dup_hit   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!tbl_vld[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_vld[i] && tbl_dest[i] == in_dest) dup_hit = 1'b1;
    end
  end

  // An entry may move once no other pending copy still reads its destination
  always_comb begin
    rdy     = '0;
    rdy_any = 1'b0;
    rdy_idx = '0;
    vld_idx = '0;
    for (int j = 0; j < DEPTH; j++) begin
      rdy[j] = tbl_vld[j];
      for (int k = 0; k < DEPTH; k++) begin
        if (k != j && tbl_vld[k] && tbl_src[k] == tbl_dest[j]) rdy[j] = 1'b0;
      end
    end
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (rdy[j]) begin
        rdy_any = 1'b1;
        rdy_idx = IDX_W'(j);
      end
      if (tbl_vld[j]) vld_idx = IDX_W'(j);
    end
    rdy_last = (tbl_vld & ~(DEPTH'(1) << rdy_idx)) == '0;
  end

  assign in_take  = (state_q == COLLECT) && in_valid;
  assign in_store = in_take && (in_dest != in_src) && have_free && !dup_hit;
  assign in_bad   = in_take && (in_dest != in_src) && (!have_free || dup_hit);

  always_comb begin
    state_d  = state_q;
    load_rdy = 1'b0;
    load_tmp = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_valid && in_last) state_d = SCHED;
      end
      SCHED: begin
        if (rdy_any) begin
          load_rdy = 1'b1;
          state_d  = EMIT;
        end else if (|tbl_vld) begin
          load_tmp = 1'b1;
          state_d  = EMIT;
        end else begin
          done_d  = 1'b1;
          state_d = COLLECT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (tbl_vld == '0) begin
            done_d  = 1'b1;
            state_d = COLLECT;
          end else begin
            state_d = SCHED;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      tbl_vld    <= '0;
      out_last_q <= 1'b0;
      set_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_done_q <= done_d;
      if (in_bad) err_q <= 1'b1;
      if (in_store) tbl_vld[free_idx] <= 1'b1;
      if (load_rdy) begin
        tbl_vld[rdy_idx] <= 1'b0;
        out_last_q       <= rdy_last;
      end
      if (load_tmp) out_last_q <= 1'b0;
    end
  end

  // Table contents and move register; the cycle-breaking rewrite redirects readers of dest_i to TMP
  always_ff @(posedge clk) begin
    if (in_store) begin
      tbl_dest[free_idx] <= in_dest;
      tbl_src[free_idx]  <= in_src;
    end
    if (load_rdy) begin
      out_dest_q <= tbl_dest[rdy_idx];
      out_src_q  <= tbl_src[rdy_idx];
    end
    if (load_tmp) begin
      out_dest_q <= TMP;
      out_src_q  <= tbl_dest[vld_idx];
      for (int j = 0; j < DEPTH; j++) begin
        if (tbl_vld[j] && tbl_src[j] == tbl_dest[vld_idx]) tbl_src[j] <= TMP;
      end
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == EMIT);
  assign out_dest  = out_dest_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign set_done  = set_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_phi_copy_sequencer.sv
// Directed bench for phi_copy_sequencer: expected moves are queued when a set is
// driven and compared by a monitor as each move handshakes.
module tb_phi_copy_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_dest, in_src;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_dest, out_src;
  logic       set_done, err;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] s;
    logic       l;
  } mv_t;

  mv_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mv_cnt = 0;
  int   done_cnt = 0;
  int   valid_cycles = 0;
  bit   prev_stall = 0;
  bit   exp_done = 0;
  logic [7:0] hold_d, hold_s;
  logic       hold_l;

  phi_copy_sequencer #(.REG_W(8), .DEPTH(8), .TMP_REG(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_src(in_src), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dest(out_dest), .out_src(out_src), .out_last(out_last),
    .set_done(set_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: scoreboard pops, hold-stability under stall, set_done after final move
  always @(negedge clk) begin
    mv_t e;
    if (rst) begin
      prev_stall = 0;
      exp_done   = 0;
    end else begin
      if (exp_done) begin
        chk("set_done_after_last", set_done, 1);
        exp_done = 0;
      end
      if (set_done) done_cnt++;
      if (out_valid) valid_cycles++;
      if (prev_stall && out_valid) begin
        chk("hold_dest", out_dest, hold_d);
        chk("hold_src", out_src, hold_s);
        chk("hold_last", out_last, hold_l);
      end
      if (out_valid && out_ready) begin
        mv_cnt++;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("move_dest", out_dest, e.d);
          chk("move_src", out_src, e.s);
          chk("move_last", out_last, e.l);
          if (e.l) exp_done = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_d = out_dest;
      hold_s = out_src;
      hold_l = out_last;
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] s, input logic l);
    in_valid = 1'b1;
    in_dest  = d;
    in_src   = s;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] s, input logic l);
    mv_t e;
    e.d = d;
    e.s = s;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (set_done) seen = 1;
    end
    chk({tag, "_set_done"}, seen, 1);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic stall_consume(input int n);
    for (int m = 0; m < n; m++) begin
      bit seen = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      chk("stall_valid_seen", seen, 1);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int v0, d0, m0;
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_dest = '0;
    in_src = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_set_done", set_done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;

    // Chain with latency check
    push(3, 2, 0);
    push(2, 1, 1);
    send(3, 2, 0);
    send(2, 1, 1);
    @(negedge clk);
    chk("chain_lat_sched", out_valid, 0);
    @(negedge clk);
    chk("chain_lat_emit", out_valid, 1);
    wait_done("chain", 20);

    // Swap
    push(255, 1, 0);
    push(1, 2, 0);
    push(2, 255, 1);
    send(1, 2, 0);
    send(2, 1, 1);
    wait_done("swap", 20);

    // Self copy: no moves, one set_done one cycle after SCHED entry
    v0 = valid_cycles;
    d0 = done_cnt;
    send(5, 5, 1);
    @(negedge clk);
    chk("self_done_early", set_done, 0);
    @(negedge clk);
    chk("self_done_pulse", set_done, 1);
    repeat (5) @(negedge clk);
    chk("self_no_valid", valid_cycles - v0, 0);
    chk("self_done_once", done_cnt - d0, 1);
    chk("self_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Swap under backpressure
    push(255, 1, 0);
    push(1, 2, 0);
    push(2, 255, 1);
    out_ready = 1'b0;
    send(1, 2, 0);
    send(2, 1, 1);
    stall_consume(3);
    out_ready = 1'b1;
    wait_done("swap_stall", 20);

    // Three-element rotation: 3 copies, 1 cycle -> 4 moves
    push(255, 1, 0);
    push(1, 2, 0);
    push(2, 3, 0);
    push(3, 255, 1);
    send(1, 2, 0);
    send(2, 3, 0);
    send(3, 1, 1);
    wait_done("rotate", 30);

    // Overflow: 9th pair dropped
    m0 = mv_cnt;
    for (int i = 0; i < 8; i++) push(8'(10 + i), 8'(20 + i), i == 7);
    for (int i = 0; i < 9; i++) send(8'(10 + i), 8'(20 + i), i == 8);
    chk("ovf_err", err, 1);
    wait_done("ovf", 40);
    chk("ovf_moves", mv_cnt - m0, 8);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_err_sticky", err, 1);

    // Reset during EMIT of a swap
    out_ready = 1'b0;
    m0 = mv_cnt;
    send(1, 2, 0);
    send(2, 1, 1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("rstmid_emit_seen", seen, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstmid_no_moves", mv_cnt - m0, 0);
    push(3, 2, 0);
    push(2, 1, 1);
    send(3, 2, 0);
    send(2, 1, 1);
    wait_done("rstmid_chain", 20);

    // Duplicate destination: second write to 4 dropped, err set
    push(9, 4, 0);
    push(4, 6, 1);
    send(4, 6, 0);
    send(4, 7, 0);
    send(9, 4, 1);
    chk("dup_err", err, 1);
    wait_done("dup", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
